muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 44 ++++
 rtl/muldiv_sign_fix.sv | 16 +
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } muldiv_state_e;

  // Divide-family ops (DIV/DIVU/REM/REMU).
  function automatic logic op_is_div(muldiv_op_e op);
    return op[2];
  endfunction

  // Remainder ops (REM/REMU).
  function automatic logic op_is_rem(muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  // Ops that interpret rs1 as a signed value.
  function automatic logic op_a_signed(muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Ops that interpret rs2 as a signed value.
  function automatic logic op_b_signed(muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: magnitude extraction and result sign fix.
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  // Negate when requested, pass through otherwise.
  always_comb begin
    res_o = val_i;
    if (neg_i) res_o = (~val_i) + W'(1);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned AW = 2 * XLEN;

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            neg_q, neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  muldiv_op_e      op_in;
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   mul_nxt;
  logic [AW:0]     div_sh;
  logic [XLEN:0]   div_top, div_diff;
  logic [AW-1:0]   div_nxt;
  logic [AW-1:0]   acc_nxt;
  logic [AW-1:0]   fix_in, fix_out;
  logic [XLEN-1:0] final_res;

  assign op_in = muldiv_op_e'(op);
  assign a_sgn = op_a_signed(op_in) & op_a[XLEN-1];
  assign b_sgn = op_b_signed(op_in) & op_b[XLEN-1];

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (.val_i(op_a), .neg_i(a_sgn), .res_o(abs_a));
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (.val_i(op_b), .neg_i(b_sgn), .res_o(abs_b));

  // Special divide cases resolved at issue without iterating.
  always_comb begin
    div_zero = op_is_div(op_in) && (op_b == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
    spec_res = '1;
    if (div_zero)     spec_res = op_is_rem(op_in) ? op_a : '1;
    else if (div_ovf) spec_res = op_is_rem(op_in) ? '0 : op_a;
  end

  // One datapath step on the shared accumulator: {hi, lo} multiply or {rem, quot} divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, opnd_q};
    mul_nxt  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[AW-1:1]};
    div_sh   = {acc_q, 1'b0};
    div_top  = div_sh[AW:XLEN];
    div_diff = div_top - {1'b0, opnd_q};
    div_nxt  = (div_top >= {1'b0, opnd_q}) ?
               {div_diff[XLEN-1:0], div_sh[XLEN-1:1], 1'b1} : div_sh[AW-1:0];
    acc_nxt  = op_is_div(op_q) ? div_nxt : mul_nxt;
  end

  // Full-width sign fix so the high product half borrows correctly from the low half.
  always_comb begin
    fix_in = acc_nxt;
    if (op_is_div(op_q))
      fix_in = {{XLEN{1'b0}}, (op_is_rem(op_q) ? acc_nxt[AW-1:XLEN] : acc_nxt[XLEN-1:0])};
  end

  muldiv_sign_fix #(.W(AW)) u_res_fix (.val_i(fix_in), .neg_i(neg_q), .res_o(fix_out));

  assign final_res = ((op_q == OP_MUL) || op_is_div(op_q)) ? fix_out[XLEN-1:0]
                                                             : fix_out[AW-1:XLEN];

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op_in;
          acc_d  = {{XLEN{1'b0}}, abs_a};
          opnd_d = abs_b;
          neg_d  = op_is_rem(op_in) ? a_sgn : (a_sgn ^ b_sgn);
          cnt_d  = '0;
          if (div_zero || div_ovf) begin
            result_d = spec_res;
            state_d  = ST_DONE;
            done_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_nxt;
        cnt_d = CW'(cnt_q + CW'(1));
        if (cnt_q == CW'(XLEN - 1)) begin
          result_d = final_res;
          state_d  = ST_DONE;
          done_d   = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
